// File: rtl/rx_frame_pkg.sv
// Shared K-character constants, word-class and FSM-state encodings for the GTP RX unpacker.
package rx_frame_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_SOF  = 8'hFB;
    localparam logic [7:0] K_EOF  = 8'hFD;

    // CLS_LOST marks a word sampled while the link was not aligned.
    typedef enum logic [2:0] {
        CLS_IDLE = 3'd0,
        CLS_SOF  = 3'd1,
        CLS_EOF  = 3'd2,
        CLS_DATA = 3'd3,
        CLS_BAD  = 3'd4,
        CLS_LOST = 3'd5
    } word_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DROP = 2'd3
    } rx_state_t;

    function automatic word_class_t classify(input logic aligned,
                                             input logic [31:0] data,
                                             input logic [3:0] charisk);
        word_class_t cls;
        cls = CLS_BAD;
        if (!aligned) begin
            cls = CLS_LOST;
        end else if (charisk == 4'b0000) begin
            cls = CLS_DATA;
        end else if (charisk == 4'b0001 && data[31:8] == 24'h0) begin
            if (data[7:0] == K_IDLE)
                cls = CLS_IDLE;
            else if (data[7:0] == K_SOF)
                cls = CLS_SOF;
            else if (data[7:0] == K_EOF)
                cls = CLS_EOF;
        end
        return cls;
    endfunction

endpackage

// File: rtl/rx_kchar_decode.sv
// Registered word classifier: one cycle of latency between the GTP word and its class.
module rx_kchar_decode
    import rx_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        aligned_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  charisk_i,
    output word_class_t cls_o,
    output logic [31:0] data_o
);

    word_class_t cls_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q  <= CLS_IDLE;
            data_q <= '0;
        end else begin
            cls_q  <= classify(aligned_i, data_i, charisk_i);
            data_q <= data_i;
        end
    end

    assign cls_o  = cls_q;
    assign data_o = data_q;

endmodule

// File: rtl/gtp_rx_unpack.sv
// GTP RX frame delimiter and 32->64 packer driving the RX buffer RAM write port.
// Optional feature macro: RX_CHKSUM_EN (trailing XOR checksum word per frame).
module gtp_rx_unpack
    import rx_frame_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int MAX_FRAME_W64 = 512
) (
    input  logic              rx_clk,
    input  logic              ap_rst,
    input  logic              gtp_rx_aligned,
    input  logic [31:0]       gtp_rx_data,
    input  logic [3:0]        gtp_rx_charisk,
    output logic              rx_wrram_en,
    output logic [ADDR_W-1:0] rx_wrram_addr,
    output logic [63:0]       rx_wrram_data,
    output logic [ADDR_W-1:0] rx_commit_addr,
    output logic [15:0]       frame_ok_cnt,
    output logic [15:0]       frame_err_cnt
);

    localparam int CNT_W = $clog2(MAX_FRAME_W64 + 1);
    localparam logic [CNT_W-1:0] WCNT_MAX = CNT_W'(MAX_FRAME_W64);

    word_class_t cls;
    logic [31:0] din;

    rx_kchar_decode u_decode (
        .clk       (rx_clk),
        .rst       (ap_rst),
        .aligned_i (gtp_rx_aligned),
        .data_i    (gtp_rx_data),
        .charisk_i (gtp_rx_charisk),
        .cls_o     (cls),
        .data_o    (din)
    );

    rx_state_t         state_q, state_d;
    logic [31:0]       lo_q, lo_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [15:0]       ok_cnt_q, ok_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              do_ok, do_err;
`ifdef RX_CHKSUM_EN
    logic [63:0]       xor_q, xor_d;
`endif

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        wcnt_d       = wcnt_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        en_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        do_ok        = 1'b0;
        do_err       = 1'b0;
`ifdef RX_CHKSUM_EN
        xor_d        = xor_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DROP: begin
                if (cls == CLS_SOF) begin
                    state_d = ST_LO;
                    wcnt_d  = '0;
`ifdef RX_CHKSUM_EN
                    xor_d   = '0;
`endif
                end else if (state_q == ST_DROP && (cls == CLS_EOF || cls == CLS_LOST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                unique case (cls)
                    CLS_SOF: begin
                        // Abort the open frame but keep this SOF as the start of the next one.
                        do_err   = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = ST_LO;
                        wcnt_d   = '0;
`ifdef RX_CHKSUM_EN
                        xor_d    = '0;
`endif
                    end
                    CLS_DATA: begin
                        if (state_q == ST_LO) begin
                            lo_d    = din;
                            state_d = ST_HI;
                        end else if (wcnt_q == WCNT_MAX) begin
                            do_err   = 1'b1;
                            wr_ptr_d = commit_ptr_q;
                            state_d  = ST_DROP;
                        end else begin
                            en_d     = 1'b1;
                            addr_d   = wr_ptr_q;
                            data_d   = {din, lo_q};
                            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                            wcnt_d   = wcnt_q + CNT_W'(1);
                            state_d  = ST_LO;
`ifdef RX_CHKSUM_EN
                            xor_d    = xor_q ^ {din, lo_q};
`endif
                        end
                    end
                    CLS_EOF: begin
                        state_d = ST_IDLE;
`ifdef RX_CHKSUM_EN
                        // The checksum slot is dropped from the committed frame and reused.
                        if (state_q == ST_LO && xor_q == '0 && wcnt_q >= CNT_W'(2)) begin
                            do_ok        = 1'b1;
                            commit_ptr_d = wr_ptr_q - ADDR_W'(1);
                            wr_ptr_d     = wr_ptr_q - ADDR_W'(1);
                        end else begin
                            do_err   = 1'b1;
                            wr_ptr_d = commit_ptr_q;
                        end
`else
                        if (state_q == ST_LO && wcnt_q != '0) begin
                            do_ok        = 1'b1;
                            commit_ptr_d = wr_ptr_q;
                        end else begin
                            do_err   = 1'b1;
                            wr_ptr_d = commit_ptr_q;
                        end
`endif
                    end
                    CLS_LOST: begin
                        do_err   = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = ST_IDLE;
                    end
                    default: begin
                        do_err   = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = ST_DROP;
                    end
                endcase
            end
        endcase
        ok_cnt_d  = (do_ok  && ok_cnt_q  != 16'hFFFF) ? ok_cnt_q  + 16'd1 : ok_cnt_q;
        err_cnt_d = (do_err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge rx_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= ST_IDLE;
            lo_q         <= '0;
            wcnt_q       <= '0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            en_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            ok_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            wcnt_q       <= wcnt_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            en_q         <= en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            ok_cnt_q     <= ok_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef RX_CHKSUM_EN
    always_ff @(posedge rx_clk or posedge ap_rst) begin
        if (ap_rst)
            xor_q <= '0;
        else
            xor_q <= xor_d;
    end
`endif

    assign rx_wrram_en    = en_q;
    assign rx_wrram_addr  = addr_q;
    assign rx_wrram_data  = data_q;
    assign rx_commit_addr = commit_ptr_q;
    assign frame_ok_cnt   = ok_cnt_q;
    assign frame_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gtp_rx_unpack.sv
// Scoreboard bench for gtp_rx_unpack, built with a 2-bit address and 4-word frame limit.
module tb_gtp_rx_unpack;

    localparam int AW   = 2;
    localparam int MAXW = 4;

    logic          rx_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          gtp_rx_aligned = 1'b1;
    logic [31:0]   gtp_rx_data = 32'h0000_00BC;
    logic [3:0]    gtp_rx_charisk = 4'b0001;
    logic          rx_wrram_en;
    logic [AW-1:0] rx_wrram_addr;
    logic [63:0]   rx_wrram_data;
    logic [AW-1:0] rx_commit_addr;
    logic [15:0]   frame_ok_cnt;
    logic [15:0]   frame_err_cnt;

    gtp_rx_unpack #(.ADDR_W(AW), .MAX_FRAME_W64(MAXW)) dut (
        .rx_clk         (rx_clk),
        .ap_rst         (ap_rst),
        .gtp_rx_aligned (gtp_rx_aligned),
        .gtp_rx_data    (gtp_rx_data),
        .gtp_rx_charisk (gtp_rx_charisk),
        .rx_wrram_en    (rx_wrram_en),
        .rx_wrram_addr  (rx_wrram_addr),
        .rx_wrram_data  (rx_wrram_data),
        .rx_commit_addr (rx_commit_addr),
        .frame_ok_cnt   (frame_ok_cnt),
        .frame_err_cnt  (frame_err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge rx_clk) begin
        if (!ap_rst && rx_wrram_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%h expected none",
                         rx_wrram_addr, rx_wrram_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write addr=%0h data=%h", rx_wrram_addr, rx_wrram_data);
                chk("wr_addr", 64'(rx_wrram_addr), 64'(mon_e.addr));
                chk("wr_data", rx_wrram_data, mon_e.data);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic al);
        @(posedge rx_clk);
        #1;
        gtp_rx_data    = d;
        gtp_rx_charisk = k;
        gtp_rx_aligned = al;
    endtask

    task automatic dw(input logic [31:0] d);   send(d, 4'b0000, 1'b1);            endtask
    task automatic sof();                      send(32'h0000_00FB, 4'b0001, 1'b1); endtask
    task automatic eof();                      send(32'h0000_00FD, 4'b0001, 1'b1); endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(32'h0000_00BC, 4'b0001, 1'b1);
    endtask

    task automatic data_run(input int first, input int n);
        for (int i = 0; i < n; i++) dw(32'(first + i));
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] hi, input logic [31:0] lo);
        wr_t e;
        e.addr = a;
        e.data = {hi, lo};
        exp_q.push_back(e);
    endtask

    task automatic check_status(input string name, input logic [AW-1:0] commit,
                                input logic [15:0] ok, input logic [15:0] err);
        idle(4);
        @(negedge rx_clk);
        $display("status %s: commit=%0d ok=%0d err=%0d", name, rx_commit_addr, frame_ok_cnt, frame_err_cnt);
        chk({name, "_commit"}, 64'(rx_commit_addr), 64'(commit));
        chk({name, "_ok"}, 64'(frame_ok_cnt), 64'(ok));
        chk({name, "_err"}, 64'(frame_err_cnt), 64'(err));
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        idle(2);
        #1;
        ap_rst = 1'b0;
        idle(2);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_en"}, 64'(rx_wrram_en), 64'd0);
        chk({name, "_addr"}, 64'(rx_wrram_addr), 64'd0);
        chk({name, "_data"}, rx_wrram_data, 64'd0);
        chk({name, "_commit"}, 64'(rx_commit_addr), 64'd0);
        chk({name, "_ok"}, 64'(frame_ok_cnt), 64'd0);
        chk({name, "_err"}, 64'(frame_err_cnt), 64'd0);
    endtask

    initial begin
        do_reset();
        @(negedge rx_clk);
        check_all_zero("reset");

`ifdef RX_CHKSUM_EN
        // Payload {2,1} with matching checksum {2,1}.
        expect_wr(0, 2, 1); expect_wr(1, 2, 1);
        sof(); dw(1); dw(2); dw(1); dw(2); eof();
        check_status("chk_good", 1, 1, 0);
        // Bad checksum {0,1}: written at 1 and 2, then rewound.
        expect_wr(1, 2, 1); expect_wr(2, 0, 1);
        sof(); dw(1); dw(2); dw(1); dw(0); eof();
        check_status("chk_bad", 1, 1, 1);
`else
        // Good four-word frame.
        expect_wr(0, 2, 1); expect_wr(1, 4, 3);
        sof(); data_run(1, 4); eof();
        check_status("good4", 2, 1, 0);

        // Odd word count, then a good frame from address 0.
        do_reset();
        expect_wr(0, 2, 1);
        sof(); data_run(1, 3); eof();
        check_status("odd3", 0, 0, 1);
        expect_wr(0, 6, 5);
        sof(); dw(5); dw(6); eof();
        check_status("after_odd", 1, 1, 1);

        // SOF mid-frame aborts the first frame, keeps the second.
        do_reset();
        expect_wr(0, 2, 1); expect_wr(0, 4, 3);
        sof(); dw(1); dw(2); sof(); dw(3); dw(4); eof();
        check_status("resof", 1, 1, 1);

        // Over-length frame: fifth write suppressed.
        do_reset();
        expect_wr(0, 2, 1); expect_wr(1, 4, 3); expect_wr(2, 6, 5); expect_wr(3, 8, 7);
        sof(); data_run(1, 10); eof();
        check_status("toolong", 0, 0, 1);

        // Pointer wrap across the 2-bit address space.
        do_reset();
        expect_wr(0, 2, 1); expect_wr(1, 4, 3); expect_wr(2, 6, 5);
        sof(); data_run(1, 6); eof();
        check_status("wrap_a", 3, 1, 0);
        expect_wr(3, 8, 7); expect_wr(0, 10, 9);
        sof(); data_run(7, 4); eof();
        check_status("wrap_b", 1, 2, 0);

        // Link loss mid-frame, then data outside a frame is ignored.
        do_reset();
        expect_wr(0, 2, 1);
        sof(); dw(1); dw(2); send(32'h0, 4'b0000, 1'b0);
        check_status("lost", 0, 0, 1);
        expect_wr(0, 6, 5);
        dw(9); sof(); dw(5); dw(6); eof();
        check_status("after_lost", 1, 1, 1);

        // Illegal K pattern drops the frame; empty frame is an error.
        expect_wr(1, 2, 1);
        sof(); dw(1); dw(2); dw(3); send(32'h0000_00BC, 4'b0011, 1'b1); dw(7); eof();
        sof(); eof();
        expect_wr(1, 6, 5);
        sof(); dw(5); dw(6); eof();
        check_status("bad_k", 2, 2, 3);

        // Asynchronous reset while a write strobe is on the port.
        sof(); dw(1); dw(2); dw(3);
        @(posedge rx_clk);
        #2;
        chk("pre_rst_en", 64'(rx_wrram_en), 64'd1);
        ap_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        idle(1);
        #1;
        ap_rst = 1'b0;
        expect_wr(0, 2, 1);
        sof(); dw(1); dw(2); eof();
        check_status("post_rst", 1, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
